// File: rtl/gecko_mem_arbiter.sv
// Two-requester round-robin arbiter for a single in-order data memory port.
// The request path and the response path are combinational. An ID FIFO
// remembers which requester owns each outstanding memory access, so each
// response goes back to the requester that issued it.
module gecko_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       req_valid,
  output logic [1:0]                       req_ready,
  input  logic [1:0]                       req_read_enable,
  input  logic [1:0][DATA_WIDTH/8-1:0]     req_write_enable,
  input  logic [1:0][ADDR_WIDTH-1:0]       req_addr,
  input  logic [1:0][DATA_WIDTH-1:0]       req_data,
  output logic [1:0]                       res_valid,
  input  logic [1:0]                       res_ready,
  output logic [DATA_WIDTH-1:0]            res_data,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_read_enable,
  output logic [DATA_WIDTH/8-1:0]          mem_req_write_enable,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  input  logic                             mem_res_valid,
  output logic                             mem_res_ready,
  input  logic [DATA_WIDTH-1:0]            mem_res_data,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             protocol_error
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                       grant_lock;
  logic                       lock_id;
  logic                       rr_pointer;
  logic [MAX_OUTSTANDING-1:0] id_fifo;
  // The counters carry one extra bit, so a full FIFO and an empty FIFO give different counts.
  logic [CNT_W-1:0]           wr_count;
  logic [CNT_W-1:0]           rd_count;

  logic grant;
  logic head_id;
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic pop;

  assign outstanding = wr_count - rd_count;
  assign fifo_full   = (outstanding == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty  = (outstanding == CNT_W'(0));
  assign head_id     = id_fifo[rd_count[PTR_W-1:0]];

  // Grant: a stalled request keeps its grant, otherwise a lone requester wins, otherwise round-robin.
  always_comb begin
    grant = rr_pointer;
    if (grant_lock) begin
      grant = lock_id;
    end else begin
      unique case (req_valid)
        2'b01:   grant = 1'b0;
        2'b10:   grant = 1'b1;
        default: grant = rr_pointer;
      endcase
    end
  end

  // Forward the granted requester's fields to memory; a full FIFO holds back new requests.
  always_comb begin
    mem_req_valid        = req_valid[grant] && !fifo_full;
    mem_req_read_enable  = req_read_enable[grant];
    mem_req_write_enable = req_write_enable[grant];
    mem_req_addr         = req_addr[grant];
    mem_req_data         = req_data[grant];
    req_ready            = '0;
    req_ready[grant]     = mem_req_ready && !fifo_full;
  end

  // Route the memory response to the FIFO head owner. With the FIFO empty, stray responses are drained.
  always_comb begin
    res_valid          = '0;
    res_valid[head_id] = mem_res_valid && !fifo_empty;
    res_data           = mem_res_data;
    mem_res_ready      = fifo_empty ? 1'b1 : res_ready[head_id];
  end

  assign accept = mem_req_valid && mem_req_ready;
  assign pop    = mem_res_valid && mem_res_ready && !fifo_empty;

  // Arbitration state, ID FIFO pointers and the sticky protocol error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_lock     <= 1'b0;
      lock_id        <= 1'b0;
      rr_pointer     <= 1'b0;
      id_fifo        <= '0;
      wr_count       <= '0;
      rd_count       <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (accept) begin
        id_fifo[wr_count[PTR_W-1:0]] <= grant;
        wr_count                     <= wr_count + CNT_W'(1);
        grant_lock                   <= 1'b0;
        rr_pointer                   <= ~grant;
      end else if (mem_req_valid) begin
        grant_lock <= 1'b1;
        lock_id    <= grant;
      end
      if (pop) begin
        rd_count <= rd_count + CNT_W'(1);
      end
      if (mem_res_valid && fifo_empty) begin
        protocol_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gecko_mem_arbiter.sv
// Scoreboard bench for gecko_mem_arbiter. When a request is accepted, the
// requester ID and the data it expects are pushed to a queue. They are popped
// and compared when the routed response appears. A small in-order memory
// model answers every accepted request.
module tb_gecko_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned MO  = 4;
  localparam logic [31:0] MAGIC = 32'hA5C3_0F96;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_read_enable;
  logic [1:0][BW-1:0]  req_write_enable;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][DW-1:0]  req_data;
  logic [1:0]          res_valid;
  logic [1:0]          res_ready;
  logic [DW-1:0]       res_data;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_read_enable;
  logic [BW-1:0]       mem_req_write_enable;
  logic [AW-1:0]       mem_req_addr;
  logic [DW-1:0]       mem_req_data;
  logic                mem_res_valid;
  logic                mem_res_ready;
  logic [DW-1:0]       mem_res_data;
  logic [$clog2(MO):0] outstanding;
  logic                protocol_error;

  gecko_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read_enable(req_read_enable), .req_write_enable(req_write_enable),
    .req_addr(req_addr), .req_data(req_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_read_enable(mem_req_read_enable), .mem_req_write_enable(mem_req_write_enable),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_res_valid(mem_res_valid), .mem_res_ready(mem_res_ready), .mem_res_data(mem_res_data),
    .outstanding(outstanding), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference state for arbitration.
  logic   m_lock;
  logic   m_lock_id;
  logic   m_rr;
  int     m_out;
  int     cnt[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lock    = 1'b0;
    m_lock_id = 1'b0;
    m_rr      = 1'b0;
    m_out     = 0;
    sb.delete();
    mem_q.delete();
  endtask

  // One clock cycle. The task is entered at a negedge. It drives the inputs,
  // checks the outputs 2 time units later, and updates the model. It returns
  // at the next negedge.
  task automatic cycle(input logic [1:0] rv, input logic mrr, input logic mresp,
                       input logic [1:0] rrdy);
    logic       eg;
    logic       full;
    logic       exp_mv;
    logic       acc;
    logic       pop;
    logic [1:0] onehot;
    for (int i = 0; i < 2; i++) begin
      req_addr[i]         = 32'h1000_0000 * (i + 1) + 32'(cnt[i] * 4);
      req_data[i]         = ~req_addr[i];
      req_read_enable[i]  = (i == 0);
      req_write_enable[i] = (i == 0) ? 4'b0000 : 4'b0101;
    end
    req_valid     = rv;
    mem_req_ready = mrr;
    res_ready     = rrdy;
    mem_res_valid = mresp && (mem_q.size() > 0);
    mem_res_data  = (mem_q.size() > 0) ? mem_q[0] : 32'h0;
    #2;
    if (m_lock)          eg = m_lock_id;
    else if (rv == 2'b01) eg = 1'b0;
    else if (rv == 2'b10) eg = 1'b1;
    else                 eg = m_rr;
    full   = (m_out == MO);
    exp_mv = rv[eg] && !full;
    check("outstanding", 64'(outstanding), 64'(m_out));
    check("mem_req_valid", 64'(mem_req_valid), 64'(exp_mv));
    if (rv != 2'b00) begin
      onehot     = 2'b00;
      onehot[eg] = mrr && !full;
      check("req_ready", 64'(req_ready), 64'(onehot));
    end
    if (exp_mv) begin
      check("mem_req_addr", 64'(mem_req_addr), 64'(req_addr[eg]));
      check("mem_req_data", 64'(mem_req_data), 64'(req_data[eg]));
      check("mem_req_we", 64'(mem_req_write_enable), 64'(req_write_enable[eg]));
      check("mem_req_re", 64'(mem_req_read_enable), 64'(req_read_enable[eg]));
    end
    acc = exp_mv && mrr;
    pop = 1'b0;
    if (sb.size() > 0) begin
      onehot              = 2'b00;
      onehot[sb[0].id]    = mem_res_valid;
      check("res_valid", 64'(res_valid), 64'(onehot));
      check("mem_res_ready", 64'(mem_res_ready), 64'(rrdy[sb[0].id]));
      if (mem_res_valid) begin
        check("res_data", 64'(res_data), 64'(sb[0].data));
        pop = rrdy[sb[0].id];
      end
    end else begin
      check("res_valid_idle", 64'(res_valid), 64'(2'b00));
      check("mem_res_ready_empty", 64'(mem_res_ready), 64'(1'b1));
    end
    if (pop) begin
      void'(sb.pop_front());
      void'(mem_q.pop_front());
      m_out--;
    end
    if (acc) begin
      sb.push_back('{id: eg, data: req_addr[eg] ^ MAGIC});
      mem_q.push_back(mem_req_addr ^ MAGIC);
      cnt[eg]++;
      m_out++;
      m_lock = 1'b0;
      m_rr   = ~eg;
    end else if (exp_mv) begin
      m_lock    = 1'b1;
      m_lock_id = eg;
    end
    @(negedge clk);
  endtask

  initial begin
    cnt[0] = 0;
    cnt[1] = 0;
    model_reset();
    rst = 1'b0;
    req_valid = '0; req_read_enable = '0; req_write_enable = '0;
    req_addr = '0; req_data = '0; res_ready = '0;
    mem_req_ready = 1'b0; mem_res_valid = 1'b0; mem_res_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
    check("rst_mem_res_ready", 64'(mem_res_ready), 64'(1));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_protocol_error", 64'(protocol_error), 64'(0));
    @(negedge clk);

    // Both requesters valid, memory always ready, responses arrive one cycle later.
    repeat (8) cycle(2'b11, 1'b1, 1'b1, 2'b11);
    repeat (2) cycle(2'b00, 1'b1, 1'b1, 2'b11);

    // Requester 1 stalls on memory for 3 cycles while requester 0 also asserts.
    cycle(2'b10, 1'b0, 1'b1, 2'b11);
    repeat (2) cycle(2'b11, 1'b0, 1'b1, 2'b11);
    repeat (2) cycle(2'b11, 1'b1, 1'b1, 2'b11);
    repeat (3) cycle(2'b00, 1'b1, 1'b1, 2'b11);

    // Memory does not respond: the FIFO fills, then one response frees a slot.
    repeat (5) cycle(2'b11, 1'b1, 1'b0, 2'b11);
    cycle(2'b11, 1'b1, 1'b1, 2'b11);
    cycle(2'b11, 1'b1, 1'b0, 2'b11);
    repeat (6) cycle(2'b00, 1'b1, 1'b1, 2'b11);

    // Requester 0 is not ready for its response, so the FIFO head is held.
    cycle(2'b01, 1'b1, 1'b0, 2'b11);
    repeat (2) cycle(2'b00, 1'b1, 1'b1, 2'b10);
    cycle(2'b00, 1'b1, 1'b1, 2'b11);
    cycle(2'b00, 1'b1, 1'b0, 2'b11);

    // A memory response with no outstanding request sets the sticky protocol error.
    mem_res_valid = 1'b1;
    mem_res_data  = 32'hDEAD_BEEF;
    #2;
    check("stray_mem_res_ready", 64'(mem_res_ready), 64'(1));
    check("stray_res_valid", 64'(res_valid), 64'(0));
    check("perr_before_edge", 64'(protocol_error), 64'(0));
    @(negedge clk);
    mem_res_valid = 1'b0;
    #2;
    check("perr_set", 64'(protocol_error), 64'(1));
    @(negedge clk);
    #2;
    check("perr_sticky", 64'(protocol_error), 64'(1));
    rst = 1'b0;
    #1;
    check("perr_cleared", 64'(protocol_error), 64'(0));
    check("reset_outstanding", 64'(outstanding), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cycle(2'b11, 1'b1, 1'b0, 2'b11);
    cycle(2'b00, 1'b1, 1'b1, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
